// File: rtl/vga_timing_driver_pkg.sv
// Shared constants, colour values, phase enum and phase-step helper for the 640x480@60 VGA timing path.
package vga_timing_pkg;

  localparam int unsigned H_DISP  = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_DISP  = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam int CNT_W = 10;
  localparam int RGB_W = 12;

  localparam logic [RGB_W-1:0] RGB_WHITE = 12'hFFF;
  localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;
  localparam logic [RGB_W-1:0] RGB_RED   = 12'hF00;
  localparam logic [RGB_W-1:0] RGB_GREEN = 12'h0F0;
  localparam logic [RGB_W-1:0] RGB_BLUE  = 12'h00F;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_e;

  // Phase for the next count value; each boundary is the first count of the following phase.
  function automatic phase_e phase_next(input phase_e cur, input logic [CNT_W-1:0] cnt_d,
                                        input logic [CNT_W-1:0] disp_end,
                                        input logic [CNT_W-1:0] fp_end,
                                        input logic [CNT_W-1:0] sync_end);
    phase_e nxt;
    nxt = cur;
    case (cur)
      ACTIVE:  if (cnt_d == disp_end) nxt = FP;
      FP:      if (cnt_d == fp_end)   nxt = SYNC;
      SYNC:    if (cnt_d == sync_end) nxt = BP;
      BP:      if (cnt_d == '0)       nxt = ACTIVE;
      default: nxt = ACTIVE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_timing_driver_if.sv
// Pixel request/return bus between the timing driver (master) and the colour stage (slave).
interface vga_timing_driver_if;
  import vga_timing_pkg::*;

  logic [CNT_W-1:0] pixel_xpos;
  logic [CNT_W-1:0] pixel_ypos;
  logic             pixel_req;
  logic [RGB_W-1:0] pixel_data;

  modport master (output pixel_xpos, output pixel_ypos, output pixel_req, input pixel_data);
  modport slave  (input pixel_xpos, input pixel_ypos, input pixel_req, output pixel_data);
endinterface

// File: rtl/vga_timing_driver_delay_line.sv
// Async-reset shift register that aligns sync/enable flags with the colour stage latency.
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_driver.sv
// VGA raster timing generator: requests pixels, realigns sync/blank to returned data, drives the pins.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN; otherwise frame_cnt is tied to zero.
module vga_timing_driver #(
  parameter int unsigned H_DISP  = vga_timing_pkg::H_DISP,
  parameter int unsigned H_FP    = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP    = vga_timing_pkg::H_BP,
  parameter int unsigned V_DISP  = vga_timing_pkg::V_DISP,
  parameter int unsigned V_FP    = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP    = vga_timing_pkg::V_BP,
  parameter int          PIX_LAT = 1
) (
  input  logic                 clk_25,
  input  logic                 rst_n,
  vga_timing_driver_if.master  pix,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic [11:0]          vga_rgb,
  output logic [15:0]          frame_cnt
);
  import vga_timing_pkg::*;

  localparam logic [CNT_W-1:0] H_DISP_END = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] H_FP_END   = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_DISP_END = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] V_FP_END   = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_DISP + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_DISP + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  phase_e           h_phase_q, h_phase_d, v_phase_q, v_phase_d;
  logic             h_wrap, v_wrap;
  logic             pixel_req_q, pixel_req_d;
  logic [CNT_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic             hs_act_q, hs_act_d, vs_act_q, vs_act_d;
  logic             hs_act_dly, vs_act_dly, de_dly;
  logic             vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
  logic [RGB_W-1:0] vga_rgb_q, vga_rgb_d;

  always_comb begin
    h_wrap    = (h_cnt_q == H_LAST);
    v_wrap    = (v_cnt_q == V_LAST);
    h_cnt_d   = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d   = v_cnt_q;
    v_phase_d = v_phase_q;
    if (h_wrap) begin
      v_cnt_d   = v_wrap ? '0 : v_cnt_q + 1'b1;
      v_phase_d = phase_next(v_phase_q, v_cnt_d, V_DISP_END, V_FP_END, V_SYNC_END);
    end
    h_phase_d = phase_next(h_phase_q, h_cnt_d, H_DISP_END, H_FP_END, H_SYNC_END);
  end

  // Request-side outputs are a registered image of the current count, so they lag it by one cycle.
  always_comb begin
    pixel_req_d = (h_phase_q == ACTIVE) && (v_phase_q == ACTIVE);
    xpos_d      = pixel_req_d ? h_cnt_q : '0;
    ypos_d      = pixel_req_d ? v_cnt_q : '0;
    hs_act_d    = (h_phase_q == SYNC);
    vs_act_d    = (v_phase_q == SYNC);
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      h_phase_q   <= ACTIVE;
      v_phase_q   <= ACTIVE;
      pixel_req_q <= 1'b0;
      xpos_q      <= '0;
      ypos_q      <= '0;
      hs_act_q    <= 1'b0;
      vs_act_q    <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      h_phase_q   <= h_phase_d;
      v_phase_q   <= v_phase_d;
      pixel_req_q <= pixel_req_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      hs_act_q    <= hs_act_d;
      vs_act_q    <= vs_act_d;
    end
  end

  // Syncs travel active-high so a flushed (all-zero) delay line means "no pulse" at the pins.
  vga_delay_line #(.WIDTH(3), .DEPTH(PIX_LAT)) u_delay (
    .clk   (clk_25),
    .rst_n (rst_n),
    .din   ({hs_act_q, vs_act_q, pixel_req_q}),
    .dout  ({hs_act_dly, vs_act_dly, de_dly})
  );

  always_comb begin
    vga_hs_d  = ~hs_act_dly;
    vga_vs_d  = ~vs_act_dly;
    vga_rgb_d = de_dly ? pix.pixel_data : RGB_BLACK;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs_q  <= 1'b1;
      vga_vs_q  <= 1'b1;
      vga_rgb_q <= RGB_BLACK;
    end else begin
      vga_hs_q  <= vga_hs_d;
      vga_vs_q  <= vga_vs_d;
      vga_rgb_q <= vga_rgb_d;
    end
  end

  assign pix.pixel_req  = pixel_req_q;
  assign pix.pixel_xpos = xpos_q;
  assign pix.pixel_ypos = ypos_q;
  assign vga_hs         = vga_hs_q;
  assign vga_vs         = vga_vs_q;
  assign vga_rgb        = vga_rgb_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = (h_wrap && v_wrap) ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench: a full-size DUT for line timing/alignment and a short-frame DUT for vsync and frame count.
module tb_vga_timing_driver;
  import vga_timing_pkg::*;

  localparam int HT  = 800;
  localparam int HD  = 640;
  localparam int HSB = 656;
  localparam int HSE = 752;
  localparam int VD_A = 480, VF_A = 10, VS_A = 2, VT_A = 525;
  localparam int VD_B = 6,   VF_B = 1,  VS_B = 2, VT_B = 10;

  logic        clk_25 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        hs_a, vs_a, hs_b, vs_b;
  logic [11:0] rgb_a, rgb_b;
  logic [15:0] fc_a, fc_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [9:0] xprev_a, xprev_b;
  logic       rprev_a, rprev_b;

  vga_timing_driver_if pix_a ();
  vga_timing_driver_if pix_b ();

  vga_timing_driver dut_a (
    .clk_25    (clk_25),
    .rst_n     (rst_n),
    .pix       (pix_a),
    .vga_hs    (hs_a),
    .vga_vs    (vs_a),
    .vga_rgb   (rgb_a),
    .frame_cnt (fc_a)
  );

  vga_timing_driver #(.V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_b (
    .clk_25    (clk_25),
    .rst_n     (rst_n),
    .pix       (pix_b),
    .vga_hs    (hs_b),
    .vga_vs    (vs_b),
    .vga_rgb   (rgb_b),
    .frame_cnt (fc_b)
  );

  always #20 clk_25 = ~clk_25;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock; the colour stage returns {2'b0,xpos} one cycle after a request, white when not requested.
  task automatic applyStimulus();
    @(posedge clk_25);
    #1;
    cyc++;
    pix_a.pixel_data = rprev_a ? {2'b00, xprev_a} : RGB_WHITE;
    pix_b.pixel_data = rprev_b ? {2'b00, xprev_b} : RGB_WHITE;
    rprev_a = pix_a.pixel_req;
    xprev_a = pix_a.pixel_xpos;
    rprev_b = pix_b.pixel_req;
    xprev_b = pix_b.pixel_xpos;
  endtask

  task automatic checkOutput(input string nm, input int n, input int vd, input int vf,
                             input int vsyn, input int vt, input logic req,
                             input logic [9:0] x, input logic [9:0] y, input logic hs,
                             input logic vsn, input logic [11:0] rgb, input logic [15:0] fc);
    int h, v, k;
    logic reqE, hsE, vsE;
    logic [9:0] xE, yE;
    logic [11:0] rgbE;
    logic [15:0] fE;
    h    = (n - 1) % HT;
    v    = ((n - 1) / HT) % vt;
    reqE = (h < HD) && (v < vd);
    xE   = reqE ? 10'(h) : 10'd0;
    yE   = reqE ? 10'(v) : 10'd0;
    k    = n - 3;
    hsE  = 1'b1;
    vsE  = 1'b1;
    rgbE = 12'h000;
    if (k >= 0) begin
      h    = k % HT;
      v    = (k / HT) % vt;
      hsE  = !(h >= HSB && h < HSE);
      vsE  = !(v >= vd + vf && v < vd + vf + vsyn);
      if (h < HD && v < vd) rgbE = 12'(h);
    end
`ifdef VGA_FRAME_CNT_EN
    fE = 16'(n / (HT * vt));
`else
    fE = 16'h0000;
`endif
    check($sformatf("%s_req@%0d", nm, n),  16'(req), 16'(reqE));
    check($sformatf("%s_xpos@%0d", nm, n), 16'(x),   16'(xE));
    check($sformatf("%s_ypos@%0d", nm, n), 16'(y),   16'(yE));
    check($sformatf("%s_hs@%0d", nm, n),   16'(hs),  16'(hsE));
    check($sformatf("%s_vs@%0d", nm, n),   16'(vsn), 16'(vsE));
    check($sformatf("%s_rgb@%0d", nm, n),  16'(rgb), 16'(rgbE));
    check($sformatf("%s_fcnt@%0d", nm, n), fc,       fE);
  endtask

  task automatic checkBoth();
    checkOutput("a", cyc, VD_A, VF_A, VS_A, VT_A, pix_a.pixel_req, pix_a.pixel_xpos,
                pix_a.pixel_ypos, hs_a, vs_a, rgb_a, fc_a);
    checkOutput("b", cyc, VD_B, VF_B, VS_B, VT_B, pix_b.pixel_req, pix_b.pixel_xpos,
                pix_b.pixel_ypos, hs_b, vs_b, rgb_b, fc_b);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_a_req"},  16'(pix_a.pixel_req),  16'h0);
    check({tag, "_a_xpos"}, 16'(pix_a.pixel_xpos), 16'h0);
    check({tag, "_a_ypos"}, 16'(pix_a.pixel_ypos), 16'h0);
    check({tag, "_a_hs"},   16'(hs_a),  16'h1);
    check({tag, "_a_vs"},   16'(vs_a),  16'h1);
    check({tag, "_a_rgb"},  16'(rgb_a), 16'h0);
    check({tag, "_a_fcnt"}, fc_a,       16'h0);
    check({tag, "_b_hs"},   16'(hs_b),  16'h1);
    check({tag, "_b_rgb"},  16'(rgb_b), 16'h0);
    check({tag, "_b_fcnt"}, fc_b,       16'h0);
  endtask

  task automatic pulseReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkReset({tag, "_immediate"});
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkReset($sformatf("%s_hold%0d", tag, i));
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int hs_low, hs_first, req_high, vs_low, fall1, fall2;
    logic vs_prev;
    hs_low   = 0;
    hs_first = -1;
    req_high = 0;
    vs_low   = 0;
    fall1    = -1;
    fall2    = -1;
    vs_prev  = 1'b1;
    rprev_a  = 1'b0;
    rprev_b  = 1'b0;
    xprev_a  = '0;
    xprev_b  = '0;
    pix_a.pixel_data = RGB_WHITE;
    pix_b.pixel_data = RGB_WHITE;

    $display("[TB] reset and release");
    for (int i = 0; i < 3; i++) applyStimulus();
    checkReset("por");
    rst_n = 1'b1;
    cyc   = 0;

    $display("[TB] free run to (h=300, v=30)");
    for (int i = 0; i < 24300; i++) begin
      applyStimulus();
      checkBoth();
      if (cyc - 3 >= HT && cyc - 3 < 2 * HT && !hs_a) begin
        hs_low++;
        if (hs_first < 0) hs_first = (cyc - 3) % HT;
      end
      if (cyc - 1 >= HT && cyc - 1 < 2 * HT && pix_a.pixel_req) req_high++;
      if (cyc - 3 >= 0 && cyc - 3 < HT * VT_B && !vs_b) vs_low++;
      if (vs_prev && !vs_b) begin
        if (fall1 < 0) fall1 = cyc;
        else if (fall2 < 0) fall2 = cyc;
      end
      vs_prev = vs_b;
    end

    check("a_hs_low_len",    16'(hs_low),   16'd96);
    check("a_hs_start_h",    16'(hs_first), 16'd656);
    check("a_req_per_line",  16'(req_high), 16'd640);
    check("b_vs_low_len",    16'(vs_low),   16'd1600);
    check("b_vs_first_fall", 16'(fall1),    16'd5603);
    check("b_vs_period",     16'(fall2 - fall1), 16'd8000);
`ifdef VGA_FRAME_CNT_EN
    check("b_frames_after_3", fc_b, 16'd3);
`else
    check("b_frames_after_3", fc_b, 16'd0);
`endif

    $display("[TB] reset mid-line at h=300");
    pulseReset("rst_mid");
    for (int i = 0; i < 2300; i++) begin
      applyStimulus();
      checkBoth();
    end

    $display("[TB] reset inside hsync");
    check("a_hs_before_rst", 16'(hs_a), 16'h0);
    pulseReset("rst_sync");
    for (int i = 0; i < 900; i++) begin
      applyStimulus();
      checkBoth();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
